// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, opcodes, data-memory FSM state and access kind.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B,
        LL    = 6'h30,
        SC    = 6'h38,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        ACC_LOAD  = 2'd0,
        ACC_STORE = 2'd1,
        ACC_LL    = 2'd2,
        ACC_SC    = 2'd3
    } acc_kind_t;

    // Classify a request; any write request is a store, even if a read is also raised.
    function automatic acc_kind_t decode_kind(input logic wen, input logic ll, input logic sc);
        if (wen) begin
            return sc ? ACC_SC : ACC_STORE;
        end
        return ll ? ACC_LL : ACC_LOAD;
    endfunction

endpackage

// File: rtl/ll_link_reg.sv
// Load-linked reservation: valid bit plus linked address, with SC match check.
module ll_link_reg
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  set_i,        // LL completed
    input  word_t set_addr_i,
    input  logic  clr_i,        // SC completed (pass or fail)
    input  logic  st_i,         // local plain store completed
    input  word_t st_addr_i,
    input  logic  inv_i,        // external invalidate
    input  word_t inv_addr_i,
    input  word_t chk_addr_i,   // SC address under test
    output logic  match_o
);

    logic  linkvalid_q;
    word_t linkaddr_q;

    // A new link always beats any same-edge clear so an LL is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            linkvalid_q <= 1'b0;
            linkaddr_q  <= '0;
        end else if (set_i) begin
            linkvalid_q <= 1'b1;
            linkaddr_q  <= set_addr_i;
        end else if (clr_i
                     || (st_i  && (st_addr_i  == linkaddr_q))
                     || (inv_i && (inv_addr_i == linkaddr_q))) begin
            linkvalid_q <= 1'b0;
        end
    end

    assign match_o = linkvalid_q && (linkaddr_q == chk_addr_i);

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data-memory sequencer: one cache access at a time, LL/SC aware.
module dmem_access
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  memREN,
    input  logic  memWEN,
    input  logic  isLL,
    input  logic  isSC,
    input  word_t addr,
    input  word_t storedata,
    input  logic  flush,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    input  logic  dhit,
    input  word_t dload,
    input  logic  linkinv,
    input  word_t linkinvaddr,
    output word_t dmemloadIN,
    output logic  stall,
    output logic  done
);

    dmem_state_t state_q;
    acc_kind_t   kind_q;
    word_t       addr_q;
    word_t       data_q;
    word_t       load_q;
    logic        flushed_q;
    logic        dren_q;
    logic        dwen_q;

    logic        accept_c;
    acc_kind_t   new_kind_c;
    logic        link_match_c;
    logic        sc_fail_c;
    logic        complete_c;

    assign accept_c     = (state_q == IDLE) && (memREN || memWEN) && !flush;
    assign new_kind_c   = decode_kind(memWEN, isLL, isSC);
    assign sc_fail_c    = accept_c && (new_kind_c == ACC_SC) && !link_match_c;
    assign complete_c   = (state_q == REQ) && dhit;

    ll_link_reg u_link (
        .clk_i      (CLK),
        .rst_i      (RST),
        .set_i      (complete_c && (kind_q == ACC_LL)),
        .set_addr_i (addr_q),
        .clr_i      (sc_fail_c || (complete_c && (kind_q == ACC_SC))),
        .st_i       (complete_c && (kind_q == ACC_STORE)),
        .st_addr_i  (addr_q),
        .inv_i      (linkinv),
        .inv_addr_i (linkinvaddr),
        .chk_addr_i (addr),
        .match_o    (link_match_c)
    );

    // Access FSM; bus strobes are registered so dhit never reaches dREN/dWEN combinationally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            kind_q    <= ACC_LOAD;
            addr_q    <= '0;
            data_q    <= '0;
            load_q    <= '0;
            flushed_q <= 1'b0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        addr_q    <= addr;
                        data_q    <= storedata;
                        kind_q    <= new_kind_c;
                        flushed_q <= 1'b0;
                        if (sc_fail_c) begin
                            // Reservation already lost: answer 0 without touching the cache.
                            load_q  <= '0;
                            state_q <= DONE;
                        end else begin
                            dren_q  <= (new_kind_c == ACC_LOAD) || (new_kind_c == ACC_LL);
                            dwen_q  <= (new_kind_c == ACC_STORE) || (new_kind_c == ACC_SC);
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A flush cannot abandon the bus transaction; it only kills the done pulse.
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (dhit) begin
                        dren_q <= 1'b0;
                        dwen_q <= 1'b0;
                        case (kind_q)
                            ACC_LOAD, ACC_LL: load_q <= dload;
                            ACC_SC:           load_q <= WORD_W'(1);
                            default:          load_q <= load_q;
                        endcase
                        state_q <= (flushed_q || flush) ? IDLE : DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dREN       = dren_q;
    assign dWEN       = dwen_q;
    assign daddr      = addr_q;
    assign dstore     = data_q;
    assign dmemloadIN = load_q;
    // The acceptance cycle must freeze the pipeline too, hence the input term.
    assign stall      = accept_c || (state_q == REQ);
    assign done       = (state_q == DONE) && !flush;

endmodule

// File: tb/tb_dmem_access.sv
// Randomized bench for dmem_access against a transaction-level LL/SC model.
module tb_dmem_access;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST;
    logic  memREN, memWEN, isLL, isSC, flush, dhit, linkinv;
    word_t addr, storedata, dload, linkinvaddr;
    logic  dREN, dWEN, stall, done;
    word_t daddr, dstore, dmemloadIN;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: reservation and last visible load/SC result.
    bit    m_lv;
    word_t m_la;
    word_t m_ld;

    localparam int K_LOAD = 0, K_STORE = 1, K_LL = 2, K_SC = 3, K_BOTH = 4;

    always #5 CLK = ~CLK;

    dmem_access dut (
        .CLK(CLK), .RST(RST), .memREN(memREN), .memWEN(memWEN), .isLL(isLL), .isSC(isSC),
        .addr(addr), .storedata(storedata), .flush(flush), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload), .linkinv(linkinv),
        .linkinvaddr(linkinvaddr), .dmemloadIN(dmemloadIN), .stall(stall), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reservation after one clock edge: invalidate/store/SC lose it, an LL (re)creates it last.
    task automatic model_edge(input bit set, input word_t set_a, input bit clr,
                              input bit st, input word_t st_a, input bit inv, input word_t inv_a);
        if (inv && inv_a == m_la) m_lv = 1'b0;
        if (st && st_a == m_la)   m_lv = 1'b0;
        if (clr)                  m_lv = 1'b0;
        if (set) begin
            m_lv = 1'b1;
            m_la = set_a;
        end
    endtask

    // Entered and left at a negedge with all requests idle.
    task automatic run_access(input int kind, input word_t a, input word_t d, input int wait_n,
                              input word_t hit_val, input bit flush_req, input bit flush_done,
                              input bit inv_at_hit, input word_t inv_a);
        bit is_wr, sc_fail;
        word_t hit_data;
        is_wr   = (kind == K_STORE) || (kind == K_SC) || (kind == K_BOTH);
        sc_fail = (kind == K_SC) && !(m_lv && m_la == a);
        hit_data = '0;
        memREN    = (kind != K_STORE) && (kind != K_SC);
        memWEN    = is_wr;
        isLL      = (kind == K_LL);
        isSC      = (kind == K_SC);
        addr      = a;
        storedata = d;
        #1;
        chk("accept_stall", 32'(stall), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        @(posedge CLK);
        if (sc_fail) model_edge(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
        @(negedge CLK);
        memREN = 1'b0; memWEN = 1'b0; isLL = 1'b0; isSC = 1'b0;
        addr = $urandom; storedata = $urandom;
        if (sc_fail) begin
            m_ld = '0;
            flush = flush_done;
            #1;
            chk("scfail_done", 32'(done), 32'(!flush_done));
            chk("scfail_dren", 32'(dREN), 32'd0);
            chk("scfail_dwen", 32'(dWEN), 32'd0);
            chk("scfail_stall", 32'(stall), 32'd0);
            chk("scfail_result", dmemloadIN, m_ld);
        end else begin
            for (int c = 0; c <= wait_n; c++) begin
                dload = $urandom;
                if (flush_req && c == 0) flush = 1'b1;
                if (c == wait_n) begin
                    dhit  = 1'b1;
                    dload = hit_val;
                    hit_data = hit_val;
                    linkinv = inv_at_hit;
                    linkinvaddr = inv_a;
                end
                #1;
                chk("req_dren", 32'(dREN), 32'(!is_wr));
                chk("req_dwen", 32'(dWEN), 32'(is_wr));
                chk("req_daddr", daddr, a);
                if (is_wr) chk("req_dstore", dstore, d);
                chk("req_stall", 32'(stall), 32'd1);
                chk("req_done", 32'(done), 32'd0);
                @(posedge CLK);
                if (c == wait_n)
                    model_edge(kind == K_LL, a, kind == K_SC,
                               kind == K_STORE || kind == K_BOTH, a, inv_at_hit, inv_a);
                @(negedge CLK);
                dhit = 1'b0; flush = 1'b0; linkinv = 1'b0;
            end
            if (kind == K_LOAD || kind == K_LL) m_ld = hit_data;
            if (kind == K_SC) m_ld = 32'd1;
            if (!flush_req) flush = flush_done;
            #1;
            chk("post_done", 32'(done), 32'(!flush_req && !flush_done));
            chk("post_dren", 32'(dREN), 32'd0);
            chk("post_dwen", 32'(dWEN), 32'd0);
            chk("post_stall", 32'(stall), 32'd0);
            chk("result", dmemloadIN, m_ld);
        end
        if (!(flush_req && !sc_fail)) begin
            @(posedge CLK);
            @(negedge CLK);
            flush = 1'b0;
            #1;
            chk("idle_done", 32'(done), 32'd0);
        end
    endtask

    task automatic idle_inv(input word_t a);
        linkinv = 1'b1;
        linkinvaddr = a;
        @(posedge CLK);
        model_edge(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, a);
        @(negedge CLK);
        linkinv = 1'b0;
    endtask

    word_t pool [4] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0300, 32'h8000_0300};

    initial begin
        RST = 1'b1;
        memREN = 0; memWEN = 0; isLL = 0; isSC = 0; flush = 0; dhit = 0; linkinv = 0;
        addr = '0; storedata = '0; dload = '0; linkinvaddr = '0;
        m_lv = 0; m_la = '0; m_ld = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_dren", 32'(dREN), 32'd0);
        chk("rst_dwen", 32'(dWEN), 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dstore", dstore, 32'd0);
        chk("rst_result", dmemloadIN, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Directed scenarios
        run_access(K_LOAD, 32'h100, 0, 2, 32'hDEADBEEF, 0, 0, 0, 0);
        run_access(K_STORE, 32'h200, 32'h12345678, 0, 32'h5555_AAAA, 0, 0, 0, 0);
        run_access(K_LL, 32'h300, 0, 1, 32'h0BAD_F00D, 0, 0, 0, 0);
        run_access(K_SC, 32'h300, 32'h77, 0, 32'h9999, 0, 0, 0, 0);
        run_access(K_SC, 32'h300, 32'h78, 0, 32'h9999, 0, 0, 0, 0);
        run_access(K_LL, 32'h300, 0, 0, 32'h1111, 0, 0, 0, 0);
        idle_inv(32'h300);
        run_access(K_SC, 32'h300, 32'h79, 0, 32'h9999, 0, 0, 0, 0);
        run_access(K_LL, 32'h300, 0, 0, 32'h2222, 0, 0, 1, 32'h300);
        run_access(K_SC, 32'h300, 32'h7A, 1, 32'h9999, 0, 0, 0, 0);
        run_access(K_LL, 32'h300, 0, 0, 32'h3333, 0, 0, 0, 0);
        run_access(K_SC, 32'h8000_0300, 32'h7B, 0, 32'h9999, 0, 0, 0, 0);
        run_access(K_LL, 32'h104, 0, 0, 32'h4444, 0, 0, 0, 0);
        run_access(K_STORE, 32'h100, 32'h1, 0, 32'h0, 0, 0, 0, 0);
        run_access(K_SC, 32'h104, 32'h7C, 0, 32'h9999, 0, 0, 0, 0);
        run_access(K_LL, 32'h104, 0, 0, 32'h5555, 0, 0, 0, 0);
        run_access(K_STORE, 32'h104, 32'h2, 2, 32'h0, 0, 0, 0, 0);
        run_access(K_SC, 32'h104, 32'h7D, 0, 32'h9999, 0, 0, 0, 0);
        run_access(K_BOTH, 32'h200, 32'hCAFE_0001, 1, 32'h6666, 0, 0, 0, 0);
        run_access(K_LOAD, 32'h100, 0, 3, 32'h7777_0000, 1, 0, 0, 0);
        run_access(K_LOAD, 32'h100, 0, 1, 32'h7777_0001, 0, 1, 0, 0);

        // Flush on the request cycle: nothing accepted
        memREN = 1'b1; addr = 32'h100; flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        memREN = 1'b0; flush = 1'b0;
        #1;
        chk("flush_idle_dren", 32'(dREN), 32'd0);
        chk("flush_idle_done", 32'(done), 32'd0);
        @(negedge CLK);

        // Reset while a load is waiting on the cache
        memREN = 1'b1; addr = 32'h140;
        @(negedge CLK);
        memREN = 1'b0;
        #1;
        chk("prerst_dren", 32'(dREN), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_lv = 0; m_la = '0; m_ld = '0;
        #1;
        chk("midrst_dren", 32'(dREN), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_result", dmemloadIN, 32'd0);
        for (int i = 0; i < 3; i++) begin
            dhit = 1'b1;
            @(negedge CLK);
            dhit = 1'b0;
            #1;
            chk("midrst_nodone", 32'(done), 32'd0);
            chk("midrst_idle_dren", 32'(dREN), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            int k;
            word_t a;
            k = int'($urandom_range(0, 4));
            a = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) idle_inv(pool[$urandom_range(0, 3)]);
            run_access(k, a, $urandom, int'($urandom_range(0, 3)), $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 5) == 0, pool[$urandom_range(0, 3)]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
